// File: rtl/lsu_mem_initiator.sv
// MEM-stage load/store unit: accepts pipeline load/store requests, drives the data-memory
// port, splits misaligned accesses into multi-cycle sequences and returns extended load data.
module lsu_mem_initiator #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned OP_W   = 3
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              busy,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              fault,
  output logic              mem_stall,
  output logic [OP_W-1:0]   mem_op,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  // Memory op_code table shared with the data memory.
  localparam logic [OP_W-1:0] OpLoadWord      = OP_W'(0);
  localparam logic [OP_W-1:0] OpStoreByte     = OP_W'(1);
  localparam logic [OP_W-1:0] OpStoreHalfWord = OP_W'(2);
  localparam logic [OP_W-1:0] OpStoreWord     = OP_W'(3);
  localparam logic [32:0]     AddrLimit       = 33'(1) << ADDR_W;

  typedef enum logic [1:0] {StIdle, StLd1, StLd2, StSt} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [31:0]         lo_q, lo_d;
  logic [1:0]          k_q, k_d;
  logic                resp_valid_q, resp_valid_d;
  logic [31:0]         resp_rdata_q, resp_rdata_d;
  logic                fault_q, fault_d;

  logic [2:0]          req_size, size_q;
  logic [32:0]         req_last;
  logic                req_illegal, req_fault, req_misaligned, accept;
  logic                ld_cross;
  logic [ADDR_W-1:0]   word_addr;

  function automatic logic [2:0] size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Shift the (possibly two-word) window down to the target byte, then truncate and extend.
  function automatic logic [31:0] extract(input logic [63:0] d, input logic [1:0] off,
                                          input logic [2:0] f3);
    logic [63:0] s;
    s = d >> {off, 3'b000};
    case (f3)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b100:  return {24'b0, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b101:  return {16'b0, s[15:0]};
      default: return s[31:0];
    endcase
  endfunction

  always_comb begin
    req_size       = size_of(req_funct3);
    req_last       = {1'b0, req_addr} + {30'b0, req_size} - 33'd1;
    req_illegal    = req_we ? (req_funct3 >= 3'b011)
                            : (req_funct3 == 3'b011 || req_funct3 >= 3'b110);
    req_fault      = req_illegal || ({1'b0, req_addr} >= AddrLimit) || (req_last >= AddrLimit);
    req_misaligned = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                     (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    accept         = req_valid && (state_q == StIdle);
    size_q         = size_of(funct3_q);
    ld_cross       = ({1'b0, addr_q[1:0]} + size_q) > 3'd4;
    word_addr      = {addr_q[ADDR_W-1:2], 2'b00};

    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    funct3_d     = funct3_q;
    lo_d         = lo_q;
    k_d          = k_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    fault_d      = 1'b0;
    mem_stall    = 1'b1;
    mem_op       = OpLoadWord;
    mem_addr     = '0;
    mem_wdata    = '0;

    unique case (state_q)
      StIdle: begin
        if (accept && req_fault) begin
          fault_d = 1'b1;
        end else if (accept) begin
          addr_d    = req_addr[ADDR_W-1:0];
          wdata_d   = req_wdata;
          funct3_d  = req_funct3;
          mem_stall = 1'b0;
          mem_wdata = req_wdata;
          if (!req_we) begin
            mem_addr = {req_addr[ADDR_W-1:2], 2'b00};
            state_d  = StLd1;
          end else if (req_misaligned) begin
            mem_op   = OpStoreByte;
            mem_addr = req_addr[ADDR_W-1:0];
            k_d      = 2'd1;
            state_d  = StSt;
          end else begin
            mem_addr = req_addr[ADDR_W-1:0];
            case (req_funct3[1:0])
              2'b00:   mem_op = OpStoreByte;
              2'b01:   mem_op = OpStoreHalfWord;
              default: mem_op = OpStoreWord;
            endcase
          end
        end
      end
      StLd1: begin
        lo_d = mem_rdata;
        if (ld_cross) begin
          mem_stall = 1'b0;
          mem_addr  = word_addr + ADDR_W'(4);
          state_d   = StLd2;
        end else begin
          resp_valid_d = 1'b1;
          resp_rdata_d = extract({32'b0, mem_rdata}, addr_q[1:0], funct3_q);
          state_d      = StIdle;
        end
      end
      StLd2: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = extract({mem_rdata, lo_q}, addr_q[1:0], funct3_q);
        state_d      = StIdle;
      end
      StSt: begin
        mem_stall = 1'b0;
        mem_op    = OpStoreByte;
        mem_addr  = addr_q + ADDR_W'(k_q);
        mem_wdata = {24'b0, wdata_q[{k_q, 3'b000} +: 8]};
        k_d       = k_q + 2'd1;
        if (k_q == 2'(size_q - 3'd1)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (!nrst) mem_stall = 1'b1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      wdata_q      <= '0;
      funct3_q     <= '0;
      lo_q         <= '0;
      k_q          <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      funct3_q     <= funct3_d;
      lo_q         <= lo_d;
      k_q          <= k_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      fault_q      <= fault_d;
    end
  end

  assign busy       = (state_q != StIdle);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign fault      = fault_q;

endmodule
